arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream request stage for the 4-way arbiter.
- Buffers transactions from four clients in per-client FIFOs and drives the arbiter's req[3:0] from FIFO occupancy.
- Consumes the arbiter's registered one-hot gnt[3:0]: pops the granted client's head entry and presents it on a single shared output stream.
- Flags protocol errors (multi-hot or spurious grants) and client starvation.

Parameters:
- DATA_W, 8, payload width per entry.
- DEPTH, 4, entries per client FIFO; power of 2, minimum 2.
- WAIT_MAX, 15, starvation threshold in cycles; minimum 1, fits in 8 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- push  in  4  per-client push strobe.
- push_data  in  4*DATA_W  client i payload in bits [i*DATA_W +: DATA_W].
- full  out  4  per-client FIFO full (count == DEPTH).
- hold  in  1  masks all req outputs while high.
- req  out  4  request vector to arbiter.
- gnt  in  4  registered grant vector from arbiter.
- out_valid  out  1  one-cycle strobe, popped entry valid.
- out_id  out  2  client index of popped entry.
- out_data  out  DATA_W  popped payload.
- starve  out  4  client waited >= WAIT_MAX cycles.
- ovf  out  4  sticky: push dropped on full FIFO.
- err_multi  out  1  pulse: gnt not zero and not one-hot.
- err_spur  out  1  pulse: one-hot gnt to a client with empty FIFO.

Behaviour:
Reset values:
- All FIFOs empty, all counts 0.
- req, full, out_valid, out_id, out_data, starve, ovf, err_multi, err_spur all 0.
- Reset mid-operation discards all queued entries immediately (asynchronous).

Push:
- Accepted when push[i] = 1 and count[i] < DEPTH. The entry is written at the clock edge.
- If count[i] == DEPTH, the push is dropped and ovf[i] is set. This holds even if a pop of client i occurs in the same cycle.
- ovf is cleared only by reset.

Pop:
- A pop occurs for client i when gnt is one-hot at bit i and count[i] > 0.
- Head entry is registered to out_data with out_id = i and out_valid = 1 in the next cycle. Latency gnt -> out_valid is 1 cycle.
- Simultaneous push and pop on the same client: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.

Request generation (combinational from registered state):
- req[i] = ~hold & ((count[i] > 1) | (count[i] == 1 & ~gnt[i])).
- This covers the arbiter's 1-cycle grant pipeline: a client with its last entry being granted this cycle drops req in the same cycle, so no second grant is issued on an empty FIFO.
- hold does not cancel grants already in flight. A gnt arriving the cycle after hold rises is still honoured.

Grant errors:
- gnt with more than one bit set: err_multi = 1 next cycle; no pop; out_valid = 0.
- gnt == 0: idle, no error.
- One-hot gnt to a client with count == 0: err_spur = 1 next cycle; no pop.

Starvation (per client, 8-bit counter wait[i]):
- Increments when req[i] = 1 and gnt[i] = 0; saturates at WAIT_MAX.
- Clears when gnt[i] = 1 or req[i] = 0.
- starve[i] = (wait[i] == WAIT_MAX), registered.

Optional Feature:
- Macro: ARB_REQ_QUEUE_STARVE_EN.
- Defined: wait counters and starve outputs behave as above.
- Undefined: counters are not instantiated and starve is tied to 4'b0000. All other behaviour is identical.

Test Plan:
1. Push client 2 payload 0xA5 once, no hold. -> req = 4'b0100 next cycle. Drive gnt = 4'b0100 one cycle later -> req drops to 0 in that same cycle; next cycle out_valid = 1, out_id = 2, out_data = 0xA5.
2. Push 5 entries (0x01..0x05) to client 0 with DEPTH = 4. -> full[0] = 1 after the 4th push; 5th push dropped, ovf[0] = 1. Four single grants pop 0x01..0x04 in order, then req[0] = 0.
3. Client 1 at count 4 (full), push and gnt[1] in the same cycle. -> push dropped, ovf[1] = 1, count becomes 3. Client 1 at count 2, push and gnt[1] same cycle -> count stays 2, payload order preserved.
4. gnt = 4'b0011 -> err_multi pulse next cycle, no out_valid, counts unchanged. gnt = 4'b1000 with client 3 empty -> err_spur pulse next cycle.
5. Client 3 holds 1 entry, gnt held at 0 for 20 cycles, WAIT_MAX = 15 -> starve[3] = 1 from wait count 15 onward. Grant to client 3 -> starve[3] = 0 on the following cycle. With macro undefined, starve stays 0.
6. Raise hold with client 0 full and gnt[0] arriving the next cycle. -> req = 0 while hold is high; the in-flight grant still pops one entry with out_valid = 1. Assert rst_n = 0 mid-stream -> all outputs 0 immediately, FIFOs empty after release.

Source files
------------

// File: rtl/arb_req_queue_if.sv
// Bundles the client push side, arbiter req/gnt side and popped output stream
// of arb_req_queue; slave is the queue, master is whatever drives clients/arbiter.
interface arb_req_queue_if #(
  parameter int DATA_W = 8
);
  // push[i] is taken only while full[i] is low (a push into a full FIFO is
  // dropped and recorded in ovf); req/gnt follow the arbiter's registered
  // one-cycle grant pipeline; out_valid is a one-cycle strobe, no back-pressure.
  logic [3:0]          push;
  logic [4*DATA_W-1:0] push_data;
  logic [3:0]          full;
  logic                hold;
  logic [3:0]          req;
  logic [3:0]          gnt;
  logic                out_valid;
  logic [1:0]          out_id;
  logic [DATA_W-1:0]   out_data;
  logic [3:0]          starve;
  logic [3:0]          ovf;
  logic                err_multi;
  logic                err_spur;

  modport master (
    output push, push_data, hold, gnt,
    input  full, req, out_valid, out_id, out_data, starve, ovf, err_multi, err_spur
  );

  modport slave (
    input  push, push_data, hold, gnt,
    output full, req, out_valid, out_id, out_data, starve, ovf, err_multi, err_spur
  );
endinterface

// File: rtl/arb_req_queue.sv
// Four per-client FIFOs feeding a 4-way arbiter: req from occupancy, pop on one-hot gnt.
// Optional starvation counters enabled by defining ARB_REQ_QUEUE_STARVE_EN.
module arb_req_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  arb_req_queue_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_param
    $error("arb_req_queue: DEPTH must be a power of 2 >= 2 and WAIT_MAX in 1..255");
  end

  logic [CW-1:0]     count  [4];
  logic [AW-1:0]     wr_ptr [4];
  logic [AW-1:0]     rd_ptr [4];
  logic [DATA_W-1:0] mem    [4][DEPTH];

  logic [3:0]        push_ok, pop, req_c, full_c;
  logic              gnt_one_hot, gnt_multi;
  logic [1:0]        gnt_idx;
  logic [DATA_W-1:0] head;

  logic              out_valid_q, err_multi_q, err_spur_q;
  logic [1:0]        out_id_q;
  logic [DATA_W-1:0] out_data_q;
  logic [3:0]        ovf_q;

  always_comb begin
    gnt_one_hot = (bus.gnt != 4'b0) && ((bus.gnt & (bus.gnt - 4'd1)) == 4'b0);
    gnt_multi   = (bus.gnt != 4'b0) && !gnt_one_hot;
    gnt_idx     = 2'd0;
    full_c      = '0;
    push_ok     = '0;
    pop         = '0;
    req_c       = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt[i]) gnt_idx = 2'(i);
      full_c[i]  = (count[i] == CNT_FULL);
      push_ok[i] = bus.push[i] && !full_c[i];
      pop[i]     = gnt_one_hot && bus.gnt[i] && (count[i] != '0);
      // A last entry already being granted must not request again.
      req_c[i]   = !bus.hold && ((count[i] > CNT_ONE) || ((count[i] == CNT_ONE) && !bus.gnt[i]));
    end
    head = mem[gnt_idx][rd_ptr[gnt_idx]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push_ok[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_ONE;
          2'b01:   count[i] <= count[i] - CNT_ONE;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage needs no reset: occupancy lives entirely in count/pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= bus.push_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 2'd0;
      out_data_q  <= '0;
      err_multi_q <= 1'b0;
      err_spur_q  <= 1'b0;
      ovf_q       <= 4'b0;
    end else begin
      out_valid_q <= |pop;
      err_multi_q <= gnt_multi;
      err_spur_q  <= gnt_one_hot && (pop == 4'b0);
      ovf_q       <= ovf_q | (bus.push & full_c);
      if (|pop) begin
        out_id_q   <= gnt_idx;
        out_data_q <= head;
      end
    end
  end

`ifdef ARB_REQ_QUEUE_STARVE_EN
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
  logic [7:0] wait_cnt [4];
  logic [3:0] starve_q;

  // starve_q tracks the next counter value so it lines up with wait_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= 8'd0;
      starve_q <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_c[i] && !bus.gnt[i]) begin
          if (wait_cnt[i] != WAIT_LIM) wait_cnt[i] <= wait_cnt[i] + 8'd1;
          starve_q[i] <= (wait_cnt[i] >= WAIT_LIM - 8'd1);
        end else begin
          wait_cnt[i] <= 8'd0;
          starve_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.starve = starve_q;
`else
  assign bus.starve = 4'b0000;
`endif

  assign bus.req       = req_c;
  assign bus.full      = full_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;
  assign bus.err_multi = err_multi_q;
  assign bus.err_spur  = err_spur_q;
endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: vector table, directed corner sequences and random
// traffic against a queue-based reference model with an output scoreboard.
module tb_arb_req_queue;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int WAIT_MAX = 15;
`ifdef ARB_REQ_QUEUE_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_req_queue_if #(.DATA_W(DW)) bus ();

  arb_req_queue #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0]   mq [4][$];
  logic [DW+1:0]   exp_q [$];
  int              wcnt [4];
  logic [3:0]      m_ovf, m_starve;
  logic            m_valid, m_em, m_es;

  logic [3:0]      cur_p, cur_g, cur_req, cur_full;
  logic [31:0]     cur_d;
  logic            cur_h;

  typedef struct {
    logic [3:0]  push;
    logic [31:0] pdata;
    logic        hold;
    logic [3:0]  gnt;
    logic [3:0]  req;
    logic [3:0]  full;
    logic        ov;
    logic [1:0]  oid;
    logic [7:0]  odata;
    logic        em;
    logic        es;
    logic [3:0]  ovf;
  } vec_t;
  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      wcnt[i] = 0;
    end
    exp_q.delete();
    m_ovf = '0; m_starve = '0; m_valid = 1'b0; m_em = 1'b0; m_es = 1'b0;
  endtask

  task automatic model_comb(input logic h, input logic [3:0] g, output logic [3:0] rq, output logic [3:0] fl);
    for (int i = 0; i < 4; i++) begin
      rq[i] = !h && ((mq[i].size() > 1) || (mq[i].size() == 1 && !g[i]));
      fl[i] = (mq[i].size() == DEPTH);
    end
  endtask

  task automatic model_edge(input logic [3:0] p, input logic [31:0] d, input logic [3:0] g, input logic [3:0] rq);
    int sz [4];
    int n;
    int idx;
    logic [DW-1:0] v;
    for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
    n = $countones(g);
    idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    m_valid = 1'b0;
    m_em = (n > 1);
    m_es = 1'b0;
    if (n == 1) begin
      if (sz[idx] > 0) begin
        v = mq[idx].pop_front();
        m_valid = 1'b1;
        exp_q.push_back({2'(idx), v});
      end else begin
        m_es = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (sz[i] == DEPTH) m_ovf[i] = 1'b1;
        else mq[i].push_back(d[i*DW +: DW]);
      end
      if (rq[i] && !g[i]) wcnt[i] = (wcnt[i] < WAIT_MAX) ? wcnt[i] + 1 : WAIT_MAX;
      else wcnt[i] = 0;
      m_starve[i] = STARVE_ON && (wcnt[i] == WAIT_MAX);
    end
  endtask

  // Called at edge+1: drive, settle, compare everything visible this cycle.
  task automatic begin_cycle(input logic [3:0] p, input logic [31:0] d, input logic h, input logic [3:0] g);
    logic [DW+1:0] e;
    bus.push = p; bus.push_data = d; bus.hold = h; bus.gnt = g;
    cur_p = p; cur_d = d; cur_h = h; cur_g = g;
    #1;
    model_comb(h, g, cur_req, cur_full);
    chk("req", 32'(bus.req), 32'(cur_req));
    chk("full", 32'(bus.full), 32'(cur_full));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("err_multi", 32'(bus.err_multi), 32'(m_em));
    chk("err_spur", 32'(bus.err_spur), 32'(m_es));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("starve", 32'(bus.starve), 32'(m_starve));
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_stream actual=%h:%h required=no entry", bus.out_id, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_id", 32'(bus.out_id), 32'(e[DW+1:DW]));
        chk("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
      end
    end
  endtask

  task automatic end_cycle();
    model_edge(cur_p, cur_d, cur_g, cur_req);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [3:0] p, input logic [31:0] d, input logic h, input logic [3:0] g);
    begin_cycle(p, d, h, g);
    end_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             push     pdata         hold  gnt      req      full     ov  oid    odata  em    es    ovf
    vecs[0]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0000, 32'h0,        1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{4'b0001, 32'h00000001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0001, 32'h00000002, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0001, 32'h00000003, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{4'b0001, 32'h00000004, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0001, 32'h00000005, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[10] = '{4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h01, 1'b0, 1'b0, 4'b0001};
    vecs[11] = '{4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h02, 1'b0, 1'b0, 4'b0001};
    vecs[12] = '{4'b0000, 32'h0,        1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h03, 1'b0, 1'b0, 4'b0001};
    vecs[13] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h04, 1'b0, 1'b0, 4'b0001};
    vecs[14] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[15] = '{4'b0010, 32'h00001100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[16] = '{4'b0000, 32'h0,        1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[17] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 4'b0001};
    vecs[18] = '{4'b0000, 32'h0,        1'b0, 4'b1000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[19] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 4'b0001};
    vecs[20] = '{4'b0000, 32'h0,        1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vecs[21] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 4'b0001};

    bus.push = '0; bus.push_data = '0; bus.hold = 1'b0; bus.gnt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_id", 32'(bus.out_id), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_errs", 32'({bus.err_multi, bus.err_spur}), 32'h0);
    chk("rst_ovf_starve", 32'({bus.ovf, bus.starve}), 32'h0);
    rst_n = 1'b1;

    // vector table: single-entry pop, overflow and ordered drain, grant errors
    for (int k = 0; k < 22; k++) begin
      begin_cycle(vecs[k].push, vecs[k].pdata, vecs[k].hold, vecs[k].gnt);
      chk($sformatf("vec%0d_req", k), 32'(bus.req), 32'(vecs[k].req));
      chk($sformatf("vec%0d_full", k), 32'(bus.full), 32'(vecs[k].full));
      chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].ov));
      chk($sformatf("vec%0d_errs", k), 32'({bus.err_multi, bus.err_spur}), 32'({vecs[k].em, vecs[k].es}));
      chk($sformatf("vec%0d_ovf", k), 32'(bus.ovf), 32'(vecs[k].ovf));
      if (vecs[k].ov) begin
        chk($sformatf("vec%0d_out_id", k), 32'(bus.out_id), 32'(vecs[k].oid));
        chk($sformatf("vec%0d_out_data", k), 32'(bus.out_data), 32'(vecs[k].odata));
      end
      end_cycle();
    end

    // push dropped on full even with a same-cycle pop; push+pop keeps count
    for (int k = 0; k < 4; k++) cycle(4'b0010, 32'(8'h30 + k) << 8, 1'b0, 4'b0000);
    begin_cycle(4'b0010, 32'h00003F00, 1'b0, 4'b0010);
    chk("full_pop_full1", 32'(bus.full[1]), 32'h1);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0010);
    chk("full_pop_ovf1", 32'(bus.ovf[1]), 32'h1);
    chk("full_pop_full1_after", 32'(bus.full[1]), 32'h0);
    chk("full_pop_data", 32'(bus.out_data), 32'h30);
    end_cycle();
    begin_cycle(4'b0010, 32'h00003400, 1'b0, 4'b0010);
    chk("pushpop_req", 32'(bus.req), 32'h2);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0010);
    chk("pushpop_data0", 32'(bus.out_data), 32'h32);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0010);
    chk("pushpop_data1", 32'(bus.out_data), 32'h33);
    chk("pushpop_last_req", 32'(bus.req), 32'h0);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
    chk("pushpop_data2", 32'(bus.out_data), 32'h34);
    end_cycle();

    // starvation of a single waiting client
    cycle(4'b1000, 32'h5A000000, 1'b0, 4'b0000);
    for (int j = 1; j <= 20; j++) begin
      begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
      chk($sformatf("starve3_c%0d", j), 32'(bus.starve[3]), 32'(STARVE_ON && (j >= 16)));
      end_cycle();
    end
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b1000);
    chk("starve3_grant_req", 32'(bus.req[3]), 32'h0);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
    chk("starve3_cleared", 32'(bus.starve[3]), 32'h0);
    chk("starve3_out", 32'({bus.out_valid, bus.out_id, bus.out_data}), 32'({1'b1, 2'd3, 8'h5A}));
    end_cycle();

    // hold with an in-flight grant, then asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) cycle(4'b0001, 32'(8'h60 + k), 1'b0, 4'b0000);
    begin_cycle(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("hold_req", 32'(bus.req), 32'h0);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b1, 4'b0001);
    chk("hold_inflight_req", 32'(bus.req), 32'h0);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b1, 4'b0000);
    chk("hold_inflight_pop", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'h60}));
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
    chk("hold_release_req", 32'(bus.req), 32'h1);
    end_cycle();
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.req), 32'h0);
    chk("arst_ovf", 32'(bus.ovf), 32'h0);
    chk("arst_out", 32'({bus.out_valid, bus.out_id, bus.out_data}), 32'h0);
    chk("arst_flags", 32'({bus.err_multi, bus.err_spur, bus.starve, bus.full}), 32'h0);
    bus.gnt = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
    chk("post_rst_req", 32'(bus.req), 32'h0);
    end_cycle();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  p, g;
      logic [31:0] d;
      logic        h;
      int          r;
      p = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      d = $urandom;
      h = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) g = 4'(1 << $urandom_range(0, 3));
      else if (r == 6) g = 4'($urandom_range(0, 15));
      else g = 4'b0000;
      cycle(p, d, h, g);
    end
    for (int n = 0; n < 3; n++) cycle(4'b0000, 32'h0, 1'b0, 4'b0000);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
